// File: rtl/host_regs_pkg.sv
// Register map, status bit positions and command codes shared by the host
// front end and its write FIFO.
package host_regs_pkg;

  typedef enum logic [1:0] {
    REG_CMD     = 2'd0,
    REG_ADDR_LO = 2'd1,
    REG_ADDR_HI = 2'd2,
    REG_DATA    = 2'd3
  } reg_sel_e;

  localparam int ST_BUSY    = 7;
  localparam int ST_FULL    = 6;
  localparam int ST_EMPTY   = 5;
  localparam int ST_OVF     = 4;
  localparam int ST_CMDDROP = 3;

  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_CLEAR = 8'h01;

  function automatic logic [7:0] status_byte(input logic busy, input logic full,
                                             input logic empty, input logic ovf,
                                             input logic cmd_drop);
    logic [7:0] s;
    s             = '0;
    s[ST_BUSY]    = busy;
    s[ST_FULL]    = full;
    s[ST_EMPTY]   = empty;
    s[ST_OVF]     = ovf;
    s[ST_CMDDROP] = cmd_drop;
    return s;
  endfunction

endpackage

// File: rtl/host_wr_fifo.sv
// Small synchronous FIFO holding queued host writes as {address, data}.
// Pointers carry one extra wrap bit so full and empty are unambiguous.
module host_wr_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/host_interface.sv
// Host register front end: turns host bus strobes into engine commands and
// queued memory writes, keeping writes and commands in program order.
module host_interface
  import host_regs_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bus_cs,
  input  logic              bus_we,
  input  logic [1:0]        bus_rs,
  input  logic [7:0]        bus_din,
  output logic [7:0]        bus_dout,
  output logic [7:0]        command,
  output logic              request,
  input  logic              active,
  output logic [ADDR_W-1:0] user_addr,
  output logic [ADDR_W-1:0] user_mem_addr,
  output logic [7:0]        user_mem_data,
  output logic              user_mem_wren
);

  localparam int ENTRY_W = ADDR_W + 8;

  logic              wr_prev_q, wr_prev_d;
  logic              rd_prev_q, rd_prev_d;
  logic              cmd_pending_q, cmd_pending_d;
  logic [7:0]        command_q, command_d;
  logic              ovf_q, ovf_d;
  logic              cmd_drop_q, cmd_drop_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              wren_q, wren_d;

  logic               wr_strobe, rd_strobe, wr_det, rd_clr;
  logic               push, pop, fifo_full, fifo_empty, request_c, busy;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
  reg_sel_e           sel;

  assign sel       = reg_sel_e'(bus_rs);
  assign wr_strobe = bus_cs & bus_we;
  assign rd_strobe = bus_cs & ~bus_we;
  assign wr_det    = wr_strobe & ~wr_prev_q;
  assign rd_clr    = rd_strobe & ~rd_prev_q & (sel == REG_CMD);

  // A command only fires once every earlier write has reached memory.
  assign request_c  = cmd_pending_q & fifo_empty & ~active & ~wren_q;
  assign pop        = ~fifo_empty & ~active & ~request_c;
  assign push       = wr_det & (sel == REG_DATA) & ~fifo_full;
  assign fifo_wdata = {ptr_q, bus_din};
  assign busy       = active | cmd_pending_q | ~fifo_empty;

  host_wr_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (push),
    .wdata(fifo_wdata),
    .pop  (pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    wr_prev_d     = wr_strobe;
    rd_prev_d     = rd_strobe;
    cmd_pending_d = cmd_pending_q;
    command_d     = command_q;
    ovf_d         = ovf_q;
    cmd_drop_d    = cmd_drop_q;
    ptr_d         = ptr_q;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    wren_d        = pop;

    if (request_c) cmd_pending_d = 1'b0;
    if (rd_clr) begin
      ovf_d      = 1'b0;
      cmd_drop_d = 1'b0;
    end

    if (wr_det) begin
      case (sel)
        REG_CMD: begin
          if (!cmd_pending_q && !active) begin
            command_d     = bus_din;
            cmd_pending_d = 1'b1;
          end else begin
            cmd_drop_d = 1'b1;
          end
        end
        REG_ADDR_LO: ptr_d[7:0]  = bus_din;
        REG_ADDR_HI: ptr_d[15:8] = bus_din;
        REG_DATA: begin
          if (!fifo_full) ptr_d = ptr_q + ADDR_W'(1);
          else            ovf_d = 1'b1;
        end
        default: ;
      endcase
    end

    if (pop) begin
      mem_addr_d = fifo_rdata[ENTRY_W-1:8];
      mem_data_d = fifo_rdata[7:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_prev_q     <= 1'b0;
      rd_prev_q     <= 1'b0;
      cmd_pending_q <= 1'b0;
      command_q     <= '0;
      ovf_q         <= 1'b0;
      cmd_drop_q    <= 1'b0;
      ptr_q         <= '0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      wren_q        <= 1'b0;
    end else begin
      wr_prev_q     <= wr_prev_d;
      rd_prev_q     <= rd_prev_d;
      cmd_pending_q <= cmd_pending_d;
      command_q     <= command_d;
      ovf_q         <= ovf_d;
      cmd_drop_q    <= cmd_drop_d;
      ptr_q         <= ptr_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      wren_q        <= wren_d;
    end
  end

  always_comb begin
    bus_dout = 8'h00;
    case (sel)
      REG_CMD:     bus_dout = status_byte(busy, fifo_full, fifo_empty, ovf_q, cmd_drop_q);
      REG_ADDR_LO: bus_dout = ptr_q[7:0];
      REG_ADDR_HI: bus_dout = ptr_q[15:8];
      default:     bus_dout = 8'h00;
    endcase
  end

  assign command       = command_q;
  assign request       = request_c;
  assign user_addr     = ptr_q;
  assign user_mem_addr = mem_addr_q;
  assign user_mem_data = mem_data_q;
  assign user_mem_wren = wren_q;

endmodule

// File: tb/tb_host_interface.sv
// Bench for host_interface: directed scenarios plus random bus traffic, all
// checked every cycle against a queue-based behavioural model.
module tb_host_interface;

  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              bus_cs, bus_we, active;
  logic [1:0]        bus_rs;
  logic [7:0]        bus_din, bus_dout, command;
  logic              request, user_mem_wren;
  logic [ADDR_W-1:0] user_addr, user_mem_addr;
  logic [7:0]        user_mem_data;

  host_interface #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .bus_cs(bus_cs), .bus_we(bus_we),
    .bus_rs(bus_rs), .bus_din(bus_din), .bus_dout(bus_dout),
    .command(command), .request(request), .active(active),
    .user_addr(user_addr), .user_mem_addr(user_mem_addr),
    .user_mem_data(user_mem_data), .user_mem_wren(user_mem_wren)
  );

  always #5 clock = ~clock;

  int n_vectors = 0;
  int n_miscompares = 0;

  // current stimulus
  bit       cur_rst, cur_cs, cur_we, cur_act;
  bit [1:0] cur_rs;
  bit [7:0] cur_din;

  // behavioural model
  bit [15:0] m_ptr;
  bit [23:0] m_fifo[$];
  bit        m_pending, m_ovf, m_drop, m_wr_prev, m_rd_prev, m_wren;
  bit [7:0]  m_cmd, m_mdata;
  bit [15:0] m_maddr;

  // observation log
  bit [23:0] obs_wr[$];
  int        n_req, cyc_no, last_wr_cyc, first_req_cyc;
  bit [7:0]  last_dout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_request();
    return m_pending && (m_fifo.size() == 0) && !cur_act && !m_wren;
  endfunction

  function automatic bit [7:0] m_dout();
    bit [7:0] s;
    s = 8'h00;
    case (cur_rs)
      2'd0: begin
        s[7] = cur_act || m_pending || (m_fifo.size() != 0);
        s[6] = (m_fifo.size() == FIFO_DEPTH);
        s[5] = (m_fifo.size() == 0);
        s[4] = m_ovf;
        s[3] = m_drop;
      end
      2'd1: s = m_ptr[7:0];
      2'd2: s = m_ptr[15:8];
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  task automatic model_reset();
    m_ptr = '0; m_fifo.delete(); m_pending = 0; m_cmd = '0; m_ovf = 0; m_drop = 0;
    m_wr_prev = 0; m_rd_prev = 0; m_wren = 0; m_maddr = '0; m_mdata = '0;
  endtask

  // effect of the coming rising edge, given the inputs now applied
  task automatic model_tick();
    bit wr_s, rd_s, wr_det, rd_clr, req, full_now;
    bit [23:0] e;
    if (cur_rst) begin
      model_reset();
      return;
    end
    wr_s     = cur_cs && cur_we;
    rd_s     = cur_cs && !cur_we;
    wr_det   = wr_s && !m_wr_prev;
    rd_clr   = rd_s && !m_rd_prev && (cur_rs == 2'd0);
    req      = m_request();
    full_now = (m_fifo.size() == FIFO_DEPTH);
    m_wren   = 0;
    if (m_fifo.size() != 0 && !cur_act && !req) begin
      e       = m_fifo.pop_front();
      m_wren  = 1;
      m_maddr = e[23:8];
      m_mdata = e[7:0];
    end
    if (rd_clr) begin
      m_ovf  = 0;
      m_drop = 0;
    end
    if (wr_det) begin
      case (cur_rs)
        2'd0: if (!m_pending && !cur_act) begin m_cmd = cur_din; m_pending = 1; end
              else m_drop = 1;
        2'd1: m_ptr[7:0]  = cur_din;
        2'd2: m_ptr[15:8] = cur_din;
        default: if (!full_now) begin m_fifo.push_back({m_ptr, cur_din}); m_ptr++; end
                 else m_ovf = 1;
      endcase
    end
    if (req) m_pending = 0;
    m_wr_prev = wr_s;
    m_rd_prev = rd_s;
  endtask

  task automatic step();
    @(negedge clock);
    reset = cur_rst; bus_cs = cur_cs; bus_we = cur_we; bus_rs = cur_rs;
    bus_din = cur_din; active = cur_act;
    #1;
    chk("request",   request,       m_request());
    chk("bus_dout",  bus_dout,      m_dout());
    chk("command",   command,       m_cmd);
    chk("user_addr", user_addr,     m_ptr);
    chk("wren",      user_mem_wren, m_wren);
    chk("mem_addr",  user_mem_addr, m_maddr);
    chk("mem_data",  user_mem_data, m_mdata);
    last_dout = bus_dout;
    if (user_mem_wren) begin
      obs_wr.push_back({user_mem_addr, user_mem_data});
      last_wr_cyc = cyc_no;
    end
    if (request) begin
      n_req++;
      if (first_req_cyc < 0) first_req_cyc = cyc_no;
    end
    cyc_no++;
    model_tick();
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input bit [1:0] rs, input bit [7:0] din);
    cur_cs = 1; cur_we = 1; cur_rs = rs; cur_din = din;
    step();
    cur_cs = 0; cur_we = 0;
    step();
  endtask

  task automatic rd(input bit [1:0] rs, output bit [7:0] dout);
    cur_cs = 1; cur_we = 0; cur_rs = rs;
    step();
    dout = last_dout;
    cur_cs = 0;
    step();
  endtask

  task automatic peek_status(output bit [7:0] dout);
    cur_cs = 0; cur_rs = 2'd0;
    step();
    dout = last_dout;
  endtask

  task automatic clear_log();
    obs_wr.delete(); n_req = 0; last_wr_cyc = -1; first_req_cyc = -1;
  endtask

  task automatic chk_wr(input string tag, input int idx, input bit [23:0] exp);
    chk(tag, (idx < obs_wr.size()) ? obs_wr[idx] : 24'h0, exp);
  endtask

  initial begin
    bit [7:0] d;
    reset = 1; bus_cs = 0; bus_we = 0; bus_rs = 0; bus_din = 0; active = 0;
    cur_rst = 0; cur_cs = 0; cur_we = 0; cur_rs = 0; cur_din = 0; cur_act = 0;
    cyc_no = 0;
    clear_log();
    repeat (2) @(posedge clock);
    model_reset();

    // reset state
    peek_status(d);
    chk("rst_status", d, 8'h20);
    chk("rst_wren", user_mem_wren, 1'b0);
    chk("rst_cmd", command, 8'h00);

    // address auto-increment
    clear_log();
    wr(2'd2, 8'h12); wr(2'd1, 8'h34);
    wr(2'd3, 8'hAA); wr(2'd3, 8'hBB); wr(2'd3, 8'hCC);
    cyc(3);
    chk("inc_n", obs_wr.size(), 3);
    chk_wr("inc_w0", 0, 24'h1234AA);
    chk_wr("inc_w1", 1, 24'h1235BB);
    chk_wr("inc_w2", 2, 24'h1236CC);
    chk("inc_ptr", user_addr, 16'h1237);
    peek_status(d);
    chk("inc_status", d, 8'h20);

    // address wrap
    clear_log();
    wr(2'd2, 8'hFF); wr(2'd1, 8'hFF);
    wr(2'd3, 8'h55); wr(2'd3, 8'h66);
    cyc(3);
    chk_wr("wrap_w0", 0, 24'hFFFF55);
    chk_wr("wrap_w1", 1, 24'h000066);
    chk("wrap_ptr", user_addr, 16'h0001);

    // overflow while engine busy
    wr(2'd2, 8'h20); wr(2'd1, 8'h00);
    clear_log();
    cur_act = 1;
    for (int i = 1; i <= 5; i++) wr(2'd3, 8'(i));
    chk("ovf_nowren", obs_wr.size(), 0);
    peek_status(d);
    chk("ovf_status", d, 8'hD0);
    cur_act = 0;
    cyc(8);
    chk("ovf_n", obs_wr.size(), 4);
    for (int i = 0; i < 4; i++) chk_wr("ovf_wr", i, {16'h2000 + 16'(i), 8'(i + 1)});
    chk("ovf_ptr", user_addr, 16'h2004);
    rd(2'd0, d);
    chk("ovf_rd1", d, 8'h30);
    rd(2'd0, d);
    chk("ovf_rd2", d, 8'h20);

    // command ordering behind queued writes
    clear_log();
    cur_act = 1;
    wr(2'd3, 8'h11); wr(2'd3, 8'h22);
    cur_act = 0;
    wr(2'd0, 8'h01);
    cyc(5);
    chk("ord_nwr", obs_wr.size(), 2);
    chk("ord_nreq", n_req, 1);
    chk("ord_after", first_req_cyc > last_wr_cyc, 1'b1);
    chk("ord_cmd", command, 8'h01);
    cur_act = 1;
    cyc(2);
    wr(2'd0, 8'h02);
    chk("drop_cmd", command, 8'h01);
    peek_status(d);
    chk("drop_status", d, 8'hA8);
    rd(2'd0, d);
    cur_act = 0;
    cyc(2);

    // long strobe: one push only
    wr(2'd2, 8'h40); wr(2'd1, 8'h10);
    clear_log();
    cur_cs = 1; cur_we = 1; cur_rs = 2'd3; cur_din = 8'h77;
    cyc(10);
    cur_cs = 0; cur_we = 0;
    cyc(3);
    chk("long_n", obs_wr.size(), 1);
    chk_wr("long_w0", 0, 24'h401077);
    chk("long_ptr", user_addr, 16'h4011);

    // reset with writes queued
    cur_act = 1;
    wr(2'd3, 8'hA1); wr(2'd3, 8'hA2); wr(2'd3, 8'hA3);
    cur_rst = 1; cur_act = 0;
    step();
    cur_rst = 0;
    clear_log();
    peek_status(d);
    chk("rst_mid_wren", obs_wr.size(), 0);
    chk("rst_mid_status", d, 8'h20);
    chk("rst_mid_ptr", user_addr, 16'h0000);
    cyc(5);
    chk("rst_mid_nwr", obs_wr.size(), 0);
    chk("rst_mid_nreq", n_req, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cur_rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) cur_act = ~cur_act;
      cur_cs  = ($urandom_range(0, 2) != 0);
      cur_we  = ($urandom_range(0, 3) != 0);
      cur_rs  = 2'($urandom_range(0, 3));
      cur_din = 8'($urandom);
      step();
    end
    cur_rst = 0; cur_cs = 0; cur_act = 0;
    cyc(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
